// File: rtl/full_adder_pkg.sv
// Shared constants and types for the registered ripple-carry full adder.
package full_adder_pkg;

  localparam int FULL_ADDER_MAX_WIDTH = 64;

  typedef struct packed {
    logic                            carry;
    logic [FULL_ADDER_MAX_WIDTH-1:0] sum;
  } fa_result_t;

  localparam logic [FULL_ADDER_MAX_WIDTH-1:0] FA_SOM_RST = '0;

  // Reset image of the registered result; the top slices sum down to WIDTH.
  localparam fa_result_t FA_RESULT_RST = '{carry: 1'b0, sum: FA_SOM_RST};

endpackage

// File: rtl/fa_slice.sv
// Purely combinational 1-bit full adder, one link of the ripple chain.
module fa_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {rout, som} = a + b + rin, one cycle latency.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
`ifdef FULL_ADDER_OVF_EN
  output logic             ovf,
`endif
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rin,
  output logic             out_valid,
  output logic [WIDTH-1:0] som,
  output logic             rout
);

  if (WIDTH < 1 || WIDTH > FULL_ADDER_MAX_WIDTH) begin : g_width_chk
    $error("full_adder: WIDTH %0d outside 1..%0d", WIDTH, FULL_ADDER_MAX_WIDTH);
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = rin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    fa_slice u_slice (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  // Result registers only load on in_valid, so idle (possibly X) operands never reach them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      som       <= FA_RESULT_RST.sum[WIDTH-1:0];
      rout      <= FA_RESULT_RST.carry;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        som  <= s;
        rout <= c[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1 and WIDTH=8 driven in lockstep.
module tb_full_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       rin;
  logic       a1, b1;
  logic [7:0] a8, b8;
  logic       out_valid1, out_valid8;
  logic       som1;
  logic [7:0] som8;
  logic       rout1, rout8;
  logic       ovf1, ovf8;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned issue;
    logic [7:0]  som;
    logic        rout;
    logic        ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t e1, e8;

`ifndef FULL_ADDER_OVF_EN
  assign ovf1 = 1'b0;
  assign ovf8 = 1'b0;
`endif

  full_adder #(.WIDTH(1)) u_dut1 (
`ifdef FULL_ADDER_OVF_EN
    .ovf       (ovf1),
`endif
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a1),
    .b         (b1),
    .rin       (rin),
    .out_valid (out_valid1),
    .som       (som1),
    .rout      (rout1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
`ifdef FULL_ADDER_OVF_EN
    .ovf       (ovf8),
`endif
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a8),
    .b         (b8),
    .rin       (rin),
    .out_valid (out_valid8),
    .som       (som8),
    .rout      (rout8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Inputs change on the falling edge; the expected result is queued with the cycle it was issued in.
  task automatic drive(input logic r, input logic v, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv);
    logic [1:0] s1;
    logic [8:0] s8;
    exp_t       e;
    rst      = r;
    in_valid = v;
    a8       = av;
    b8       = bv;
    a1       = av[0];
    b1       = bv[0];
    rin      = cv;
    if (v && !r) begin
      s1      = {1'b0, av[0]} + {1'b0, bv[0]} + {1'b0, cv};
      e.issue = cyc;
      e.som   = {7'b0, s1[0]};
      e.rout  = s1[1];
      e.ovf   = s1[1] ^ cv;
      q1.push_back(e);
      s8      = {1'b0, av} + {1'b0, bv} + {8'b0, cv};
      e.som   = s8[7:0];
      e.rout  = s8[8];
      e.ovf   = (av[7] == bv[7]) && (s8[7] != av[7]);
      q8.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].issue == cyc - 1) begin
      e1 = q1.pop_front();
      check("w1_valid", out_valid1, 1'b1);
      check("w1_som", som1, e1.som[0]);
      check("w1_rout", rout1, e1.rout);
`ifdef FULL_ADDER_OVF_EN
      check("w1_ovf", ovf1, e1.ovf);
`endif
    end else begin
      check("w1_idle_valid", out_valid1, 1'b0);
    end
    if (q8.size() > 0 && q8[0].issue == cyc - 1) begin
      e8 = q8.pop_front();
      check("w8_valid", out_valid8, 1'b1);
      check("w8_som", som8, e8.som);
      check("w8_rout", rout8, e8.rout);
`ifdef FULL_ADDER_OVF_EN
      check("w8_ovf", ovf8, e8.ovf);
`endif
    end else begin
      check("w8_idle_valid", out_valid8, 1'b0);
    end
  end

  task automatic check_cleared(input string tag);
    check({tag, "_w1_som"}, som1, 1'b0);
    check({tag, "_w1_rout"}, rout1, 1'b0);
    check({tag, "_w1_ovf"}, ovf1, 1'b0);
    check({tag, "_w8_som"}, som8, 8'h00);
    check({tag, "_w8_rout"}, rout8, 1'b0);
    check({tag, "_w8_ovf"}, ovf8, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a1       = 1'bx;
    b1       = 1'bx;
    a8       = 'x;
    b8       = 'x;
    rin      = 1'bx;

    step();
    drive(1'b1, 1'b0, 8'hxx, 8'hxx, 1'bx);
    step();
    // Valid input during reset must be discarded.
    drive(1'b1, 1'b1, 8'hFF, 8'h01, 1'b1);
    step();
    check_cleared("rst");

    drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b1); step();
    drive(1'b0, 1'b1, 8'h01, 8'h00, 1'b1); step();
    drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b1); step();
    drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b0); step();
    drive(1'b0, 1'b1, 8'hFF, 8'h01, 1'b0); step();
    drive(1'b0, 1'b1, 8'h7F, 8'h01, 1'b0); step();

    // Stall with unknown operands: outputs must hold the 0x7F+0x01 result.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'hxx, 8'hxx, 1'bx);
      step();
      if (i > 0) begin
        check("hold_w1_som", som1, 1'b0);
        check("hold_w1_rout", rout1, 1'b1);
        check("hold_w8_som", som8, 8'h80);
        check("hold_w8_rout", rout8, 1'b0);
`ifdef FULL_ADDER_OVF_EN
        check("hold_w8_ovf", ovf8, 1'b1);
`endif
      end
    end

    for (int i = 0; i < 8; i++) begin
      logic [7:0] av, bv;
      av = {7'($urandom), i[2]};
      bv = {7'($urandom), i[1]};
      drive(1'b0, 1'b1, av, bv, i[0]);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      step();
    end

    // Reset in the middle of a stream.
    drive(1'b0, 1'b1, 8'hC3, 8'h5A, 1'b1); step();
    drive(1'b1, 1'b1, 8'h80, 8'h80, 1'b0); step();
    check_cleared("midrst");
    drive(1'b0, 1'b1, 8'h80, 8'h80, 1'b1); step();
    drive(1'b0, 1'b0, 8'hxx, 8'hxx, 1'bx); step();
    step();

    check("w1_queue_empty", q1.size(), 0);
    check("w8_queue_empty", q8.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
